// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: EX-stage condition evaluation, registered redirect/mispredict, 2-bit BHT predictor.
// Optional performance counters are enabled by defining BRU_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CNT_INIT    = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            flush,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  input  logic            ex_pred_taken,
  output logic            take_branch,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic            illegal_branch
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  function automatic logic [1:0] sat_upd(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic [1:0]            bht_q [BHT_ENTRIES];
  logic [IDX_W-1:0]      fetch_idx, ex_idx;
  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic                  resolve, outcome, illegal;
  logic                  take_d, take_q, mis_d, mis_q, ill_d, ill_q;
  logic [XLEN-1:0]       redir_d, redir_q;
  logic                  unused_pc_bits;

  assign fetch_idx      = fetch_pc[IDX_W+1:2];
  assign ex_idx         = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0], ex_pc[1:0]};
  // Read is the registered table contents, so a same-cycle update is not visible.
  assign pred_taken     = bht_q[fetch_idx][1];

  assign rs1_s   = rs1;
  assign rs2_s   = rs2;
  assign resolve = ex_valid & ex_is_branch & ~flush;

  always_comb begin
    outcome = 1'b0;
    illegal = 1'b0;
    case (funct3)
      3'b000:  outcome = (rs1 == rs2);
      3'b001:  outcome = (rs1 != rs2);
      3'b100:  outcome = (rs1_s < rs2_s);
      3'b101:  outcome = (rs1_s >= rs2_s);
      3'b110:  outcome = (rs1 < rs2);
      3'b111:  outcome = (rs1 >= rs2);
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    take_d  = 1'b0;
    mis_d   = 1'b0;
    ill_d   = 1'b0;
    redir_d = redir_q;
    if (resolve) begin
      take_d  = outcome;
      mis_d   = (outcome != ex_pred_taken) | (illegal & ex_pred_taken);
      ill_d   = illegal;
      redir_d = outcome ? ex_target : ex_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      take_q  <= 1'b0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
      redir_q <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CNT_INIT;
    end else begin
      take_q  <= take_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
      redir_q <= redir_d;
      if (resolve && !illegal) bht_q[ex_idx] <= sat_upd(bht_q[ex_idx], outcome);
    end
  end

  assign take_branch    = take_q;
  assign mispredict     = mis_q;
  assign illegal_branch = ill_q;
  assign redirect_pc    = redir_q;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] br_cnt_q, mis_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (resolve && !illegal && br_cnt_q != 32'hFFFF_FFFF) br_cnt_q <= br_cnt_q + 32'd1;
      if (mis_d && mis_cnt_q != 32'hFFFF_FFFF) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign br_count      = br_cnt_q;
  assign mispred_count = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed corner cases plus randomized traffic
// checked against a counter-table reference model.
module tb_branch_resolve_unit;
  localparam int XLEN = 32;
  localparam int N    = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] fetch_pc, ex_pc, ex_target, rs1, rs2;
  logic            ex_valid, ex_is_branch, flush, ex_pred_taken;
  logic [2:0]      funct3;
  logic            pred_taken, take_branch, mispredict, illegal_branch;
  logic [XLEN-1:0] redirect_pc;
`ifdef BRU_PERF_CNT_EN
  logic [31:0]     br_count, mispred_count;
  int              m_br, m_mis;
`endif

  int          checks   = 0;
  int          failures = 0;
  int          cnt [N];
  logic [31:0] m_redir;

  branch_resolve_unit #(.XLEN(XLEN), .BHT_ENTRIES(N), .CNT_INIT(2'b01)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .flush(flush),
    .ex_pc(ex_pc), .ex_target(ex_target), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .ex_pred_taken(ex_pred_taken), .take_branch(take_branch), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .illegal_branch(illegal_branch)
`ifdef BRU_PERF_CNT_EN
    , .br_count(br_count), .mispred_count(mispred_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) cnt[i] = 1;
    m_redir = '0;
`ifdef BRU_PERF_CNT_EN
    m_br  = 0;
    m_mis = 0;
`endif
  endtask

  function automatic longint to_signed(input logic [31:0] v);
    return v[31] ? longint'(v) - 64'sh1_0000_0000 : longint'(v);
  endfunction

  task automatic ref_outcome(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             output bit oc, output bit ill);
    longint sa, sb, ua, ub;
    sa = to_signed(a); sb = to_signed(b);
    ua = longint'(a);  ub = longint'(b);
    oc = 0; ill = 0;
    case (f)
      3'd0: oc = (ua == ub);
      3'd1: oc = (ua != ub);
      3'd4: oc = (sa <  sb);
      3'd5: oc = (sa >= sb);
      3'd6: oc = (ua <  ub);
      3'd7: oc = (ua >= ub);
      default: ill = 1;
    endcase
  endtask

  task automatic drive(input bit v, input bit b, input bit fl, input logic [31:0] fpc,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] a,
                       input logic [31:0] bb, input logic [2:0] f, input bit pt);
    ex_valid = v; ex_is_branch = b; flush = fl; fetch_pc = fpc;
    ex_pc = pc; ex_target = tgt; rs1 = a; rs2 = bb; funct3 = f; ex_pred_taken = pt;
  endtask

  task automatic idle(input logic [31:0] fpc);
    drive(0, 0, 0, fpc, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 0);
  endtask

  // Checks the combinational prediction, advances one clock, checks registered outputs.
  task automatic step();
    int fi, ui;
    bit res, oc, ill, et, em, ei;
    #1;
    fi = (int'(fetch_pc) >>> 2) & (N - 1);
    chk("pred_taken", pred_taken, cnt[fi] >= 2);
    res = ex_valid && ex_is_branch && !flush;
    ref_outcome(funct3, rs1, rs2, oc, ill);
    et = 0; em = 0; ei = 0;
    if (res) begin
      et = oc; ei = ill;
      em = (oc != ex_pred_taken) || (ill && ex_pred_taken);
      m_redir = oc ? ex_target : ex_pc + 32'd4;
      if (!ill) begin
        ui = (int'(ex_pc) >>> 2) & (N - 1);
        cnt[ui] = oc ? ((cnt[ui] == 3) ? 3 : cnt[ui] + 1) : ((cnt[ui] == 0) ? 0 : cnt[ui] - 1);
`ifdef BRU_PERF_CNT_EN
        m_br++;
`endif
      end
`ifdef BRU_PERF_CNT_EN
      if (em) m_mis++;
`endif
    end
    @(posedge clk);
    #1;
    chk("take_branch", take_branch, et);
    chk("mispredict", mispredict, em);
    chk("illegal_branch", illegal_branch, ei);
    chk("redirect_pc", redirect_pc, m_redir);
`ifdef BRU_PERF_CNT_EN
    chk("br_count", br_count, m_br);
    chk("mispred_count", mispred_count, m_mis);
`endif
  endtask

  logic [31:0] a, b, pc;

  initial begin
    rst_n = 1'b0;
    idle(32'h100);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_take", take_branch, 0);
    chk("rst_mis", mispredict, 0);
    chk("rst_ill", illegal_branch, 0);
    chk("rst_redir", redirect_pc, 0);
    chk("rst_pred_0x100", pred_taken, 0);
    rst_n = 1'b1;

    // BEQ taken at 0x100, predicted not-taken
    drive(1, 1, 0, 32'h100, 32'h100, 32'h400, 32'd5, 32'd5, 3'd0, 0);
    step();
    chk("beq_take", take_branch, 1);
    chk("beq_mis", mispredict, 1);
    chk("beq_redir", redirect_pc, 32'h400);
    idle(32'h100);
    #1 chk("beq_pred_after", pred_taken, 1);
    step();

    // Signed vs unsigned less-than on the same operands
    drive(1, 1, 0, 32'h300, 32'h300, 32'h380, 32'hFFFF_FFFF, 32'd1, 3'd4, 0);
    step();
    chk("blt_take", take_branch, 1);
    drive(1, 1, 0, 32'h300, 32'h300, 32'h380, 32'hFFFF_FFFF, 32'd1, 3'd6, 0);
    step();
    chk("bltu_take", take_branch, 0);
    chk("bltu_redir", redirect_pc, 32'h304);

    // Saturation at 11: four taken, then two not-taken
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 32'h200, 32'h200, 32'h240, 32'd7, 32'd7, 3'd0, 1);
      step();
    end
    drive(1, 1, 0, 32'h200, 32'h200, 32'h240, 32'd7, 32'd7, 3'd1, 1);
    step();
    idle(32'h200);
    #1 chk("sat_pred_after_one_nt", pred_taken, 1);
    drive(1, 1, 0, 32'h200, 32'h200, 32'h240, 32'd7, 32'd7, 3'd1, 1);
    step();
    idle(32'h200);
    #1 chk("sat_pred_after_two_nt", pred_taken, 0);

    // PC+4 wraps
    drive(1, 1, 0, 32'h0, 32'hFFFF_FFFC, 32'h80, 32'd1, 32'd2, 3'd0, 0);
    step();
    chk("wrap_redir", redirect_pc, 32'h0);

    // Illegal funct3 with taken prediction
    drive(1, 1, 0, 32'h500, 32'h500, 32'h540, 32'd3, 32'd3, 3'd2, 1);
    step();
    chk("illegal_flag", illegal_branch, 1);
    chk("illegal_mis", mispredict, 1);
    chk("illegal_take", take_branch, 0);
    idle(32'h500);
    #1 chk("illegal_pred_unchanged", pred_taken, 0);

    // Flush kills a valid taken branch
    drive(1, 1, 1, 32'h600, 32'h600, 32'h640, 32'd9, 32'd9, 3'd0, 0);
    step();
    chk("flush_take", take_branch, 0);
    chk("flush_mis", mispredict, 0);
    idle(32'h600);
    #1 chk("flush_pred_unchanged", pred_taken, 0);

    // Reset asserted while a resolve is pending
    drive(1, 1, 0, 32'h100, 32'h100, 32'h700, 32'd1, 32'd1, 3'd0, 0);
    step();
    drive(1, 1, 0, 32'h100, 32'h100, 32'h700, 32'd1, 32'd1, 3'd0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_take", take_branch, 0);
    chk("midrst_mis", mispredict, 0);
    chk("midrst_redir", redirect_pc, 0);
    chk("midrst_pred", pred_taken, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(32'h100);
    step();

    // Randomized traffic over a small PC window so counters saturate both ways
    for (int n = 0; n < 400; n++) begin
      pc = 32'h1000 + ($urandom_range(0, 9) << 2);
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 1) ? $urandom : ~a);
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
            32'h1000 + ($urandom_range(0, 9) << 2), pc, $urandom, a, b,
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
